// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial accelerator.
// Consumers: fact_unit (controller/register file) and fact_dp (datapath).
package fact_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StMult,
        StDone
    } state_t;

    localparam logic [1:0] SEL_N    = 2'b00;
    localparam logic [1:0] SEL_GO   = 2'b01;
    localparam logic [1:0] SEL_STAT = 2'b10;
    localparam logic [1:0] SEL_RES  = 2'b11;

    localparam int unsigned DEFAULT_MAX_N = 12;

endpackage

// File: rtl/fact_dp.sv
// Factorial datapath: down-counter, running product, multiplier and result register.
module fact_dp
    import fact_pkg::*;
#(
    parameter int unsigned N_WIDTH    = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [N_WIDTH-1:0]    n_in,
    input  logic                  step,
    input  logic                  res_prod,
    input  logic                  res_one,
    input  logic                  res_zero,
    output logic                  more,
    output logic [DATA_WIDTH-1:0] result
);

    logic [N_WIDTH-1:0]    cnt;
    logic [DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] prod_next;

    assign prod_next = prod * DATA_WIDTH'(cnt);

    // Set when the counter is still above 1 after this step, so the last
    // multiply is written straight into result on the finishing edge.
    assign more = cnt > N_WIDTH'(2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            prod   <= '0;
            result <= '0;
        end else begin
            if (load) begin
                cnt  <= n_in;
                prod <= DATA_WIDTH'(1);
            end else if (step) begin
                cnt  <= cnt - N_WIDTH'(1);
                prod <= prod_next;
            end
            if (res_prod) begin
                result <= prod_next;
            end else if (res_one) begin
                result <= DATA_WIDTH'(1);
            end else if (res_zero) begin
                result <= '0;
            end
        end
    end

endmodule

// File: rtl/fact_unit.sv
// Memory-mapped iterative factorial accelerator: register file, controller FSM, read mux.
// Optional FACT_IRQ_EN adds a one-cycle irq pulse when done rises.
module fact_unit
    import fact_pkg::*;
#(
    parameter int unsigned N_WIDTH    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_N      = DEFAULT_MAX_N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WE1,
    input  logic                  WE2,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic [1:0]            RdSel,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  busy,
    output logic                  done,
    output logic                  err
`ifdef FACT_IRQ_EN
    ,
    output logic                  irq
`endif
);

    state_t                state;
    logic [N_WIDTH-1:0]    n_reg;
    logic                  go_reg;
    logic                  start;
    logic                  n_over;
    logic                  n_small;
    logic                  more;
    logic                  in_load;
    logic                  in_mult;
    logic [DATA_WIDTH-1:0] result;

    assign start   = WE2 & WD[0] & ((state == StIdle) | (state == StDone));
    assign n_over  = 32'(n_reg) > MAX_N;
    assign n_small = n_reg < N_WIDTH'(2);
    assign in_load = state == StLoad;
    assign in_mult = state == StMult;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StIdle;
            n_reg  <= '0;
            go_reg <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
`ifdef FACT_IRQ_EN
            irq    <= 1'b0;
`endif
        end else begin
            if (WE1) n_reg <= WD[N_WIDTH-1:0];
            if (WE2) go_reg <= WD[0];
`ifdef FACT_IRQ_EN
            irq <= 1'b0;
`endif
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state <= StLoad;
                        done  <= 1'b0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                StLoad: begin
                    // 0! and 1! need no multiply; finishing here keeps latency at 2 edges.
                    if (n_over || n_small) begin
                        state <= StDone;
                        err   <= n_over;
                        done  <= 1'b1;
                        busy  <= 1'b0;
`ifdef FACT_IRQ_EN
                        irq   <= 1'b1;
`endif
                    end else begin
                        state <= StMult;
                    end
                end
                StMult: begin
                    if (!more) begin
                        state <= StDone;
                        done  <= 1'b1;
                        busy  <= 1'b0;
`ifdef FACT_IRQ_EN
                        irq   <= 1'b1;
`endif
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    fact_dp #(
        .N_WIDTH    (N_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (in_load),
        .n_in     (n_reg),
        .step     (in_mult),
        .res_prod (in_mult & ~more),
        .res_one  (in_load & ~n_over & n_small),
        .res_zero (in_load & n_over),
        .more     (more),
        .result   (result)
    );

    always_comb begin
        RD = '0;
        case (RdSel)
            SEL_N:    RD = DATA_WIDTH'(n_reg);
            SEL_GO:   RD = DATA_WIDTH'(go_reg);
            SEL_STAT: RD = DATA_WIDTH'({err, done});
            SEL_RES:  RD = result;
            default:  RD = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_unit.sv
// Self-checking bench for fact_unit with a factorial reference model and random runs.
module tb_fact_unit;

    logic        clk;
    logic        rst;
    logic        WE1;
    logic        WE2;
    logic [31:0] WD;
    logic [1:0]  RdSel;
    logic [31:0] RD;
    logic        busy;
    logic        done;
    logic        err;
`ifdef FACT_IRQ_EN
    logic        irq;
`endif

    int errors = 0;
    int checks = 0;

    fact_unit dut (
        .clk   (clk),
        .rst   (rst),
        .WE1   (WE1),
        .WE2   (WE2),
        .WD    (WD),
        .RdSel (RdSel),
        .RD    (RD),
        .busy  (busy),
        .done  (done),
        .err   (err)
`ifdef FACT_IRQ_EN
        ,
        .irq   (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic from the behavioural rules.
    function automatic logic [31:0] ref_result(input int n);
        logic [31:0] p;
        if (n > 12) return 32'd0;
        p = 32'd1;
        for (int k = 2; k <= n; k++) p = p * k;
        return p;
    endfunction

    function automatic int ref_latency(input int n);
        if (n > 12) return 2;
        return ((n < 1) ? 1 : n) + 1;
    endfunction

    // All stimulus tasks start and end at a falling edge.
    task automatic write_n(input int n);
        WE1 = 1'b1;
        WD  = n;
        @(negedge clk);
        WE1 = 1'b0;
        WD  = '0;
    endtask

    task automatic pulse_go(input logic v);
        WE2 = 1'b1;
        WD  = {31'd0, v};
        @(negedge clk);
        WE2 = 1'b0;
        WD  = '0;
    endtask

    task automatic rd(input logic [1:0] s, output logic [31:0] v);
        RdSel = s;
        #1;
        v = RD;
    endtask

    // Advances until done is seen, counting edges since the start edge.
    task automatic wait_done(input int already, output int edges);
        edges = already;
        while (!done && edges < 60) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset;
        logic [31:0] v;
        int e;
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000", {busy, done, err});
        end
        write_n(7);
        pulse_go(1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_busy: got %b want 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async_flags: got %b want 000", {busy, done, err});
        end
`ifdef FACT_IRQ_EN
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
`endif
        for (int s = 0; s < 4; s++) begin
            rd(s[1:0], v);
            checks++;
            if (v !== 32'd0) begin
                errors++;
                $display("FAIL reset_rd sel=%0d: got %0d want 0", s, v);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wait_done(0, e);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_restart: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_basic;
        logic [31:0] v;
        int e;
        write_n(5);
        pulse_go(1'b1);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: busy=%b done=%b want 1 0", busy, done);
        end
        wait_done(1, e);
        checks++;
        if (e !== 6) begin
            errors++;
            $display("FAIL basic_latency: got %0d want 6", e);
        end
        rd(2'b11, v);
        checks++;
        if (v !== 32'd120) begin
            errors++;
            $display("FAIL basic_result: got %0d want 120", v);
        end
        rd(2'b10, v);
        checks++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL basic_status: got %0d want 1", v);
        end
        rd(2'b00, v);
        checks++;
        if (v !== 32'd5) begin
            errors++;
            $display("FAIL basic_nreg: got %0d want 5", v);
        end
        rd(2'b01, v);
        checks++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL basic_go: got %0d want 1", v);
        end
    endtask

    task automatic test_small_and_limits;
        int ns[4] = '{0, 1, 12, 13};
        logic [31:0] v;
        int e;
        foreach (ns[i]) begin
            write_n(ns[i]);
            pulse_go(1'b1);
            wait_done(1, e);
            checks++;
            if (e !== ref_latency(ns[i])) begin
                errors++;
                $display("FAIL limit_latency n=%0d: got %0d want %0d", ns[i], e,
                         ref_latency(ns[i]));
            end
            rd(2'b11, v);
            checks++;
            if (v !== ref_result(ns[i])) begin
                errors++;
                $display("FAIL limit_result n=%0d: got %0d want %0d", ns[i], v,
                         ref_result(ns[i]));
            end
            checks++;
            if (err !== (ns[i] > 12)) begin
                errors++;
                $display("FAIL limit_err n=%0d: got %b want %b", ns[i], err, ns[i] > 12);
            end
        end
    endtask

    task automatic test_busy_interference;
        logic [31:0] v;
        int e;
        write_n(6);
        pulse_go(1'b1);
        write_n(3);
        pulse_go(1'b1);
        wait_done(3, e);
        checks++;
        if (e !== 7) begin
            errors++;
            $display("FAIL busy_latency: got %0d want 7", e);
        end
        rd(2'b11, v);
        checks++;
        if (v !== 32'd720) begin
            errors++;
            $display("FAIL busy_result: got %0d want 720", v);
        end
        rd(2'b01, v);
        checks++;
        if (v !== 32'd1) begin
            errors++;
            $display("FAIL busy_go: got %0d want 1", v);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_no_restart: done=%b busy=%b want 1 0", done, busy);
        end
        pulse_go(1'b1);
        wait_done(1, e);
        rd(2'b11, v);
        checks++;
        if (v !== 32'd6 || e !== 4) begin
            errors++;
            $display("FAIL busy_next: result=%0d edges=%0d want 6 4", v, e);
        end
    endtask

    // WD=7 writes n=7 and go=1 together; the new n must be used.
    task automatic test_simultaneous;
        logic [31:0] v;
        int e;
        WE1 = 1'b1;
        WE2 = 1'b1;
        WD  = 32'd7;
        @(negedge clk);
        WE1 = 1'b0;
        WE2 = 1'b0;
        WD  = '0;
        wait_done(1, e);
        rd(2'b11, v);
        checks++;
        if (v !== 32'd5040 || e !== 8) begin
            errors++;
            $display("FAIL simul_we: result=%0d edges=%0d want 5040 8", v, e);
        end
    endtask

    task automatic test_random;
        logic [31:0] v;
        logic [31:0] prev;
        int n;
        int e;
        prev = ref_result(7);
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(0, 15);
            write_n(n);
            pulse_go(1'b1);
            rd(2'b11, v);
            checks++;
            if (v !== prev) begin
                errors++;
                $display("FAIL rand_hold it=%0d: got %0d want %0d", it, v, prev);
            end
            wait_done(1, e);
            rd(2'b11, v);
            checks++;
            if (v !== ref_result(n) || e !== ref_latency(n) || err !== (n > 12)
                || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_run n=%0d: result=%0d edges=%0d err=%b busy=%b want %0d %0d %b 0",
                         n, v, e, err, busy, ref_result(n), ref_latency(n), n > 12);
            end
            prev = ref_result(n);
        end
    endtask

`ifdef FACT_IRQ_EN
    task automatic test_irq;
        int pulses = 0;
        int bad = 0;
        logic prev_done;
        write_n(4);
        prev_done = done;
        pulse_go(1'b1);
        prev_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (irq) pulses++;
            if (irq !== (done && !prev_done)) bad++;
            prev_done = done;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 1 || bad !== 0) begin
            errors++;
            $display("FAIL irq_pulse: pulses=%0d misaligned=%0d want 1 0", pulses, bad);
        end
    endtask
`endif

    initial begin
        rst   = 1'b1;
        WE1   = 1'b0;
        WE2   = 1'b0;
        WD    = '0;
        RdSel = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_small_and_limits;
        test_busy_interference;
        test_simultaneous;
        test_random;
`ifdef FACT_IRQ_EN
        test_irq;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
